mario_sprite_renderer: RTL and testbench
========================================

Name: mario_sprite_renderer

Overview:
Downstream consumer of the Mario mover's mario_x/mario_y. Overlays the Mario sprite onto the background pixel stream from the VGA/background path.
- Latches position and facing once per frame, so the sprite never tears mid-scan.
- Mirrors the sprite when Mario faces left and runs a 2-frame walk animation.
- Fetches texels from an external synchronous sprite ROM.
- Emits the final pixel colour with sync signals delayed to match.

Parameters:
MARIO_WIDTH, 42, sprite edge in pixels (sprite is square)
SCREEN_WIDTH, 640, visible width
SCREEN_HEIGHT, 480, visible height
COLOR_W, 12, pixel colour width (4:4:4 RGB)
TRANSPARENT, 12'hF0F, ROM colour treated as see-through
ADDR_W, 12, sprite ROM address width (2 x 42 x 42 = 3528 words)
ANIM_FRAMES, 8, frames per walk-animation step
LATENCY, 3, fixed pipeline depth (informative; not to be overridden)

Ports:
vga_clock  in  1  pixel clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
mario_x  in  32  sprite left edge from mover
mario_y  in  32  sprite top edge from mover
left  in  1  left button (facing tracking)
right  in  1  right button (facing tracking)
frame_start  in  1  one-cycle pulse at first vertical-blanking pixel
pixel_x  in  10  current scan column
pixel_y  in  10  current scan row
video_on  in  1  visible-area flag
hsync_in  in  1  horizontal sync from VGA timing
vsync_in  in  1  vertical sync from VGA timing
bg_color  in  COLOR_W  background colour for (pixel_x, pixel_y)
rom_addr  out  ADDR_W  sprite ROM address (registered)
rom_data  in  COLOR_W  ROM texel; valid one cycle after rom_addr
pixel_color  out  COLOR_W  final colour
hsync_out  out  1  hsync_in delayed LATENCY cycles
vsync_out  out  1  vsync_in delayed LATENCY cycles
sprite_hit  out  1  1 when pixel_color came from an opaque sprite texel

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Outputs: pixel_color=0, sprite_hit=0, hsync_out=1, vsync_out=1, rom_addr=0.
  - All pipeline valid/inside bits cleared.
  - Latched position: lx=0, ly=360. Facing right. anim=0, anim_cnt=0, prev_lx=0.
  - Applies identically mid-frame; the first post-reset outputs are driven from fresh inputs after LATENCY edges.
- Facing register, updated every cycle:
  - left & ~right -> left.
  - right & ~left -> right.
  - both or neither -> hold.
- Frame latch, on frame_start=1 only:
  - lx<=mario_x, ly<=mario_y, lface<=facing, prev_lx<=lx.
  - Animation step:
    - If mario_x != lx (moving), anim_cnt increments. When anim_cnt reaches ANIM_FRAMES-1, anim_cnt wraps to 0 and anim toggles.
    - If not moving, anim_cnt=0 and anim=0 (standing pose).
  - Between frame_start pulses, lx/ly/lface/anim are frozen regardless of mover changes.
- Stage 0 (combinational, on inputs):
  - inside = video_on & (pixel_x >= lx) & (pixel_x < lx+MARIO_WIDTH) & (pixel_y >= ly) & (pixel_y < ly+MARIO_WIDTH).
  - Comparisons are 32-bit unsigned, with pixel coords zero-extended.
  - A sprite partially off the right or bottom edge is clipped naturally. lx >= SCREEN_WIDTH gives no hits.
  - dx=pixel_x-lx, dy=pixel_y-ly.
  - col = lface ? MARIO_WIDTH-1-dx : dx.
  - addr = anim*MARIO_WIDTH*MARIO_WIDTH + dy*MARIO_WIDTH + col, truncated to ADDR_W. Computed only meaningfully when inside; rom_addr holds its previous value when not inside.
- Stage 1 (edge 1): register rom_addr, inside1, bg1, von1, hs1, vs1.
- Stage 2 (edge 2): ROM captures the address. rom_data is valid during this cycle. Register inside2, bg2, von2, hs2, vs2.
- Stage 3 (edge 3, outputs):
  - ~von2 -> pixel_color=0, sprite_hit=0.
  - inside2 & rom_data != TRANSPARENT -> pixel_color=rom_data, sprite_hit=1.
  - Otherwise -> pixel_color=bg2, sprite_hit=0.
  - hsync_out=hs2, vsync_out=vs2.
- Latency is exactly 3 edges from inputs to pixel_color/sync, with no bubbles. Throughput is one pixel per clock.
- frame_start coinciding with a visible pixel is not legal upstream. If it occurs, the new latch takes effect for the next cycle's stage-0 computation.

Test Plan:
- Reset then release; lx=0, ly=360, video_on=1, pixel=(0,360), rom_data=12'h0A0 -> rom_addr=0 after 1 edge; pixel_color=12'h0A0, sprite_hit=1 after 3 edges.
- Transparency: pixel inside sprite, rom_data=12'hF0F, bg_color=12'h00F -> pixel_color=12'h00F, sprite_hit=0.
- Mirror: after right=1 then left=1 and a frame_start, lx=100, pixel_x=100, dy=0 -> rom_addr=41. Facing right, same pixel -> rom_addr=0.
- Frame latching: mario_x changes 100->150 mid-frame without frame_start -> hits still span x=100..141. After frame_start, hits span 150..191.
- Animation: mario_x increases by 1 before each of 8 consecutive frame_starts -> anim toggles to 1. Next address base is 1764 (pixel (lx,ly) facing right -> rom_addr=1764). A stationary frame -> anim=0.
- Clipping/blanking: lx=620, pixel_x=639 -> hit; video_on=0 -> pixel_color=0. hsync_in/vsync_in toggles appear on outputs exactly 3 edges later. Reset asserted mid-line -> pixel_color=0 on the next edge.

Source files
------------

// File: rtl/mario_sprite_renderer_if.sv
// Pixel-stream bundle between the VGA/background path, the Mario mover,
// the sprite ROM and the sprite renderer.
interface mario_sprite_renderer_if #(
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 12
);
    // Free-running stream, one pixel per clock: no valid/ready pair and no
    // backpressure; every output is aligned with its input LATENCY edges earlier.
    logic [31:0]        mario_x;
    logic [31:0]        mario_y;
    logic               left;
    logic               right;
    logic               frame_start;
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic               video_on;
    logic               hsync_in;
    logic               vsync_in;
    logic [COLOR_W-1:0] bg_color;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [COLOR_W-1:0] pixel_color;
    logic               hsync_out;
    logic               vsync_out;
    logic               sprite_hit;

    modport master (
        output mario_x, mario_y, left, right, frame_start, pixel_x, pixel_y,
               video_on, hsync_in, vsync_in, bg_color, rom_data,
        input  rom_addr, pixel_color, hsync_out, vsync_out, sprite_hit
    );

    modport slave (
        input  mario_x, mario_y, left, right, frame_start, pixel_x, pixel_y,
               video_on, hsync_in, vsync_in, bg_color, rom_data,
        output rom_addr, pixel_color, hsync_out, vsync_out, sprite_hit
    );
endinterface

// File: rtl/mario_sprite_renderer.sv
// Overlays the Mario sprite on the background stream through a 3-stage
// pipeline around a synchronous sprite ROM; position/facing latched per frame.
module mario_sprite_renderer #(
    parameter int                 MARIO_WIDTH = 42,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F,
    parameter int                 ADDR_W      = 12,
    parameter int                 ANIM_FRAMES = 8
) (
    input  logic                  vga_clock,
    input  logic                  reset_n,
    mario_sprite_renderer_if.slave bus
);
    localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic              face_q, face_d;     // 1 = facing left
    logic [31:0]       lx_q, lx_d, ly_q, ly_d;
    logic              lface_q, lface_d;
    logic              anim_q, anim_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        face_d  = face_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        lface_d = lface_q;
        anim_d  = anim_q;
        cnt_d   = cnt_q;
        if (bus.left & ~bus.right) begin
            face_d = 1'b1;
        end else if (bus.right & ~bus.left) begin
            face_d = 1'b0;
        end
        if (bus.frame_start) begin
            lx_d    = bus.mario_x;
            ly_d    = bus.mario_y;
            lface_d = face_q;
            // Walk cycle only advances while the sprite moved since the last frame.
            if (bus.mario_x != lx_q) begin
                if (cnt_q == CNT_W'(ANIM_FRAMES - 1)) begin
                    cnt_d  = '0;
                    anim_d = ~anim_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d  = '0;
                anim_d = 1'b0;
            end
        end
    end

    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            face_q  <= 1'b0;
            lx_q    <= 32'd0;
            ly_q    <= 32'd360;
            lface_q <= 1'b0;
            anim_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            face_q  <= face_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            lface_q <= lface_d;
            anim_q  <= anim_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [31:0]       px_w, py_w;
    logic              inside_c;
    logic [ADDR_W-1:0] dx_c, dy_c, col_c, addr_c;

    always_comb begin
        px_w     = {22'd0, bus.pixel_x};
        py_w     = {22'd0, bus.pixel_y};
        inside_c = bus.video_on
                 & (px_w >= lx_q) & (px_w < lx_q + 32'(MARIO_WIDTH))
                 & (py_w >= ly_q) & (py_w < ly_q + 32'(MARIO_WIDTH));
        // Offsets only matter modulo the ROM size, so keep them ADDR_W wide.
        dx_c     = ADDR_W'(px_w - lx_q);
        dy_c     = ADDR_W'(py_w - ly_q);
        col_c    = lface_q ? (ADDR_W'(MARIO_WIDTH - 1) - dx_c) : dx_c;
        addr_c   = (anim_q ? ADDR_W'(MARIO_WIDTH * MARIO_WIDTH) : '0)
                 + dy_c * ADDR_W'(MARIO_WIDTH) + col_c;
    end

    logic [ADDR_W-1:0]  rom_addr_q;
    logic               in1_q, von1_q, hs1_q, vs1_q;
    logic               in2_q, von2_q, hs2_q, vs2_q;
    logic [COLOR_W-1:0] bg1_q, bg2_q;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               hit_q, hit_d, hs_out_q, vs_out_q;

    always_comb begin
        color_d = bg2_q;
        hit_d   = 1'b0;
        if (!von2_q) begin
            color_d = '0;
        end else if (in2_q && (bus.rom_data != TRANSPARENT)) begin
            color_d = bus.rom_data;
            hit_d   = 1'b1;
        end
    end

    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            in1_q      <= 1'b0;
            von1_q     <= 1'b0;
            bg1_q      <= '0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            in2_q      <= 1'b0;
            von2_q     <= 1'b0;
            bg2_q      <= '0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            color_q    <= '0;
            hit_q      <= 1'b0;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
        end else begin
            if (inside_c) begin
                rom_addr_q <= addr_c;
            end
            in1_q    <= inside_c;
            von1_q   <= bus.video_on;
            bg1_q    <= bus.bg_color;
            hs1_q    <= bus.hsync_in;
            vs1_q    <= bus.vsync_in;
            in2_q    <= in1_q;
            von2_q   <= von1_q;
            bg2_q    <= bg1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            color_q  <= color_d;
            hit_q    <= hit_d;
            hs_out_q <= hs2_q;
            vs_out_q <= vs2_q;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.pixel_color = color_q;
    assign bus.sprite_hit  = hit_q;
    assign bus.hsync_out   = hs_out_q;
    assign bus.vsync_out   = vs_out_q;
endmodule

// File: tb/tb_mario_sprite_renderer.sv
// Directed + randomized bench for mario_sprite_renderer with a frame-level
// reference model and an expected-output queue aligned to the 3-edge latency.
module tb_mario_sprite_renderer;
    localparam int          MW     = 42;
    localparam logic [11:0] TRANSP = 12'hF0F;

    logic vga_clock = 1'b0;
    logic reset_n   = 1'b0;
    always #5 vga_clock = ~vga_clock;

    mario_sprite_renderer_if bus ();

    mario_sprite_renderer dut (
        .vga_clock (vga_clock),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    logic [11:0] rom_mem [4096];
    always @(posedge vga_clock) bus.rom_data <= rom_mem[bus.rom_addr];

    int passed = 0;
    int total  = 0;
    logic [14:0] exp_q[$];  // {hsync, vsync, hit, colour}

    // Reference state: what the frame latch should hold right now.
    logic [31:0] m_lx, m_ly;
    bit          m_face, m_lface, m_anim;
    int          m_steps;
    logic [11:0] m_rom_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lx = 0; m_ly = 360; m_face = 0; m_lface = 0; m_anim = 0; m_steps = 0;
        m_rom_addr = 0;
        exp_q.delete();
    endtask

    // One clock: predict from current inputs, advance the model, clock, compare.
    task automatic tick();
        logic [31:0] px, py;
        int unsigned dx, dy, col, a;
        bit          ins;
        logic [11:0] texel, color;
        bit          hit;
        logic [14:0] got;
        logic [14:0] exp;
        bus.hsync_in = 1'($urandom_range(0, 1));
        bus.vsync_in = 1'($urandom_range(0, 1));
        if (!reset_n) begin
            model_reset();
            @(posedge vga_clock); #1;
            return;
        end
        px  = {22'd0, bus.pixel_x};
        py  = {22'd0, bus.pixel_y};
        ins = bus.video_on && px >= m_lx && px < m_lx + MW && py >= m_ly && py < m_ly + MW;
        color = bus.bg_color;
        hit   = 0;
        if (ins) begin
            dx  = px - m_lx;
            dy  = py - m_ly;
            col = m_lface ? (MW - 1 - dx) : dx;
            a   = (m_anim ? MW * MW : 0) + dy * MW + col;
            m_rom_addr = a[11:0];
            texel = rom_mem[m_rom_addr];
            if (texel != TRANSP) begin
                color = texel;
                hit   = 1;
            end
        end
        if (!bus.video_on) color = 12'h000;
        exp_q.push_back({bus.hsync_in, bus.vsync_in, hit, color});
        if (bus.frame_start) begin
            if (bus.mario_x != m_lx) begin
                m_steps++;
                if (m_steps == 8) begin
                    m_steps = 0;
                    m_anim  = !m_anim;
                end
            end else begin
                m_steps = 0;
                m_anim  = 0;
            end
            m_lx = bus.mario_x; m_ly = bus.mario_y; m_lface = m_face;
        end
        if (bus.left && !bus.right) m_face = 1;
        else if (bus.right && !bus.left) m_face = 0;
        @(posedge vga_clock); #1;
        check("rom_addr", 32'(bus.rom_addr), 32'(m_rom_addr));
        if (exp_q.size() == 3) begin
            exp = exp_q.pop_front();
            got = {bus.hsync_out, bus.vsync_out, bus.sprite_hit, bus.pixel_color};
            check("pixel_color", 32'(got[11:0]), 32'(exp[11:0]));
            check("sprite_hit", 32'(got[12]), 32'(exp[12]));
            check("vsync_out", 32'(got[13]), 32'(exp[13]));
            check("hsync_out", 32'(got[14]), 32'(exp[14]));
        end
    endtask

    task automatic set_pix(input int x, input int y, input bit von);
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.video_on = von;
        bus.bg_color = 12'($urandom_range(0, 4095));
    endtask

    task automatic frame(input int x, input int y);
        bus.mario_x     = 32'(x);
        bus.mario_y     = 32'(y);
        bus.video_on    = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            rom_mem[i] = 12'($urandom_range(0, 12'hF0E));
            if (i % 11 == 5) rom_mem[i] = TRANSP;
        end
        rom_mem[0] = 12'h0A0;
        rom_mem[1] = TRANSP;
        bus.mario_x = 0; bus.mario_y = 360; bus.left = 0; bus.right = 0;
        bus.frame_start = 0; bus.hsync_in = 1; bus.vsync_in = 1;
        set_pix(0, 360, 1'b1);
        #2;

        // Reset state
        reset_n = 1'b0;
        tick(); tick();
        check("rst_pixel_color", 32'(bus.pixel_color), 32'h0);
        check("rst_sprite_hit", 32'(bus.sprite_hit), 32'h0);
        check("rst_hsync_out", 32'(bus.hsync_out), 32'h1);
        check("rst_vsync_out", 32'(bus.vsync_out), 32'h1);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);

        // First pixel after release: default latch (0,360)
        reset_n = 1'b1;
        set_pix(0, 360, 1'b1);
        tick();
        check("first_rom_addr", 32'(bus.rom_addr), 32'd0);
        tick(); tick();
        check("first_color", 32'(bus.pixel_color), 32'h0A0);
        check("first_hit", 32'(bus.sprite_hit), 32'h1);

        // Transparent texel shows the background
        set_pix(1, 360, 1'b1);
        bus.bg_color = 12'h00F;
        tick(); tick(); tick();
        check("transp_color", 32'(bus.pixel_color), 32'h00F);
        check("transp_hit", 32'(bus.sprite_hit), 32'h0);

        // Mirror when facing left
        set_pix(0, 0, 1'b0);
        bus.right = 1; tick();
        bus.right = 0; bus.left = 1; tick();
        bus.left = 0;
        frame(100, 200);
        set_pix(100, 200, 1'b1);
        tick();
        check("mirror_left_addr", 32'(bus.rom_addr), 32'd41);
        set_pix(0, 0, 1'b0);
        bus.right = 1; tick();
        bus.right = 0;
        frame(100, 200);
        set_pix(100, 200, 1'b1);
        tick();
        check("mirror_right_addr", 32'(bus.rom_addr), 32'd0);

        // Mover changes mid-frame are ignored until frame_start
        bus.mario_x = 150;
        for (int x = 90; x <= 200; x++) begin
            set_pix(x, 210, 1'b1);
            tick();
        end
        frame(150, 200);
        for (int x = 140; x <= 200; x++) begin
            set_pix(x, 210, 1'b1);
            tick();
        end

        // Walk animation: 8 moving frames toggle the pose, one still frame resets it
        frame(150, 200);
        for (int i = 1; i <= 8; i++) frame(150 + i, 200);
        set_pix(158, 200, 1'b1);
        tick();
        check("anim_addr", 32'(bus.rom_addr), 32'd1764);
        frame(158, 200);
        set_pix(158, 200, 1'b1);
        tick();
        check("stand_addr", 32'(bus.rom_addr), 32'd0);

        // Right-edge clipping and blanking
        frame(620, 300);
        set_pix(639, 310, 1'b1);
        tick(); tick(); tick();
        check("clip_hit", 32'(bus.sprite_hit), 32'h1);
        set_pix(639, 310, 1'b0);
        tick(); tick(); tick();
        check("blank_color", 32'(bus.pixel_color), 32'h0);
        frame(700, 100);
        for (int x = 600; x < 760; x += 4) begin
            set_pix(x, 120, 1'b1);
            tick();
        end

        // Randomized traffic around the sprite
        for (int n = 0; n < 1200; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 1) == 1) frame(int'(m_lx), int'(m_ly));
                else frame($urandom_range(0, 700), $urandom_range(0, 470));
            end
            bus.left  = 1'($urandom_range(0, 1));
            bus.right = 1'($urandom_range(0, 1));
            set_pix(int'(m_lx) + $urandom_range(0, 60) - 8,
                    int'(m_ly) + $urandom_range(0, 60) - 8,
                    $urandom_range(0, 4) != 0);
            tick();
        end

        // Reset in the middle of a visible line
        bus.left = 0; bus.right = 0;
        set_pix(int'(m_lx), int'(m_ly), 1'b1);
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        check("midrst_color", 32'(bus.pixel_color), 32'h0);
        check("midrst_hit", 32'(bus.sprite_hit), 32'h0);
        check("midrst_hsync", 32'(bus.hsync_out), 32'h1);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_pix($urandom_range(0, 50), 360 + $urandom_range(0, 50), 1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
